// File: rtl/gray_seq_checker.sv
// Gray-sequence checker: samples an upstream Gray counter, decodes it to binary,
// and tracks lock, wrap-arounds and illegal steps against the last accepted sample.
module gray_seq_checker #(
    parameter int N        = 4,
    parameter int LOCK_LEN = 2,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N-1:0]      gray_in,
    input  logic              clr,
    output logic [N-1:0]      bin_out,
    output logic              bin_valid,
    output logic              locked,
    output logic              step_err,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam int K_W = 4;
    localparam logic [K_W-1:0] LOCK_K = K_W'(LOCK_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_reg;
    logic [N-1:0]       s_gray_reg;
    logic               s_v_reg;
    logic [N-1:0]       ref_g_reg;
    logic [N-1:0]       ref_b_reg;
    logic [K_W-1:0]     k_reg;

    logic [N-1:0]       dec_b;
    logic [N-1:0]       diff;
    logic               is_hold;
    logic               one_bit;
    logic               is_succ;
    logic               is_valid;
    logic               is_wrap;
    logic [K_W-1:0]     k_next;
    logic [ERR_W-1:0]   err_base;
    logic [ERR_W-1:0]   err_next;
    logic [WRAP_W-1:0]  wrap_base;
    logic [WRAP_W-1:0]  wrap_next;
    logic               sticky_base;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dec
            assign dec_b[gi] = ^s_gray_reg[N-1:gi];
        end
    endgenerate

    always_comb begin
        diff        = s_gray_reg ^ ref_g_reg;
        is_hold     = (diff == '0);
        one_bit     = !is_hold && ((diff & (diff - N'(1))) == '0);
        is_succ     = (dec_b == ref_b_reg + N'(1));
        is_valid    = one_bit && is_succ;
        is_wrap     = is_valid && (ref_b_reg == '1) && (dec_b == '0);
        k_next      = k_reg + K_W'(1);
        // clr takes effect before any coincident event on the same edge.
        err_base    = clr ? '0 : err_cnt;
        wrap_base   = clr ? '0 : wrap_cnt;
        sticky_base = clr ? 1'b0 : err_sticky;
        err_next    = (err_base == '1) ? err_base : err_base + ERR_W'(1);
        wrap_next   = wrap_base + WRAP_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            s_gray_reg <= '0;
            s_v_reg    <= 1'b0;
            ref_g_reg  <= '0;
            ref_b_reg  <= '0;
            k_reg      <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            locked     <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            wrap_pulse <= 1'b0;
            err_cnt    <= err_base;
            wrap_cnt   <= wrap_base;
            err_sticky <= sticky_base;

            if (en) begin
                s_gray_reg <= gray_in;
                s_v_reg    <= 1'b1;
            end else begin
                s_v_reg    <= 1'b0;
            end

            if (s_v_reg) begin
                bin_out   <= dec_b;
                bin_valid <= 1'b1;
                case (state_reg)
                    IDLE: begin
                        ref_g_reg <= s_gray_reg;
                        ref_b_reg <= dec_b;
                        k_reg     <= '0;
                        state_reg <= ACQ;
                    end
                    ACQ: begin
                        if (!is_hold) begin
                            ref_g_reg <= s_gray_reg;
                            ref_b_reg <= dec_b;
                            if (is_valid) begin
                                if (k_next == LOCK_K) begin
                                    state_reg <= LOCKED;
                                    locked    <= 1'b1;
                                    k_reg     <= '0;
                                end else begin
                                    k_reg     <= k_next;
                                end
                            end else begin
                                step_err   <= 1'b1;
                                err_sticky <= 1'b1;
                                k_reg      <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!is_hold) begin
                            ref_g_reg <= s_gray_reg;
                            ref_b_reg <= dec_b;
                            if (is_valid) begin
                                if (is_wrap) begin
                                    wrap_pulse <= 1'b1;
                                    wrap_cnt   <= wrap_next;
                                end
                            end else begin
                                step_err   <= 1'b1;
                                err_sticky <= 1'b1;
                                err_cnt    <= err_next;
                                state_reg  <= ACQ;
                                locked     <= 1'b0;
                                k_reg      <= '0;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed bench for gray_seq_checker: a sample-level model is compared every cycle,
// and literal expectations at the key points pin that model.
module tb_gray_seq_checker;

    localparam int N        = 4;
    localparam int LOCK_LEN = 2;
    localparam int WRAP_W   = 8;
    localparam int ERR_W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              clr = 1'b0;
    logic [N-1:0]      gray_in = '0;
    logic [N-1:0]      bin_out;
    logic              bin_valid;
    logic              locked;
    logic              step_err;
    logic              err_sticky;
    logic [ERR_W-1:0]  err_cnt;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_cnt;

    always #5 clk = ~clk;

    gray_seq_checker #(
        .N(N), .LOCK_LEN(LOCK_LEN), .WRAP_W(WRAP_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .gray_in(gray_in), .clr(clr),
        .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
        .step_err(step_err), .err_sticky(err_sticky), .err_cnt(err_cnt),
        .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_wp_seen   = 0;
    int n_serr_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] bin2gray(input int b);
        logic [N-1:0] v;
        v = b[N-1:0];
        return v ^ (v >> 1);
    endfunction

    function automatic int gray2bin(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) r = r ^ (int'(g) >> i);
        return r & ((1 << N) - 1);
    endfunction

    // Sample-level model state
    bit m_have_ref, m_locked, m_pv, m_good;
    int m_ref_g, m_ref_b, m_run, m_pg, m_b;
    int e_bin, e_bv, e_se, e_st, e_ec, e_wp, e_wc;

    initial begin : model_compare
        m_have_ref = 0; m_locked = 0; m_pv = 0; m_pg = 0;
        m_ref_g = 0; m_ref_b = 0; m_run = 0;
        e_bin = 0; e_bv = 0; e_se = 0; e_st = 0; e_ec = 0; e_wp = 0; e_wc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                m_have_ref = 0; m_locked = 0; m_pv = 0; m_run = 0;
                e_bin = 0; e_bv = 0; e_se = 0; e_st = 0; e_ec = 0; e_wp = 0; e_wc = 0;
            end else begin
                e_bv = 0; e_se = 0; e_wp = 0;
                if (clr) begin e_ec = 0; e_wc = 0; e_st = 0; end
                if (m_pv) begin
                    m_b   = gray2bin(m_pg[N-1:0]);
                    e_bin = m_b;
                    e_bv  = 1;
                    if (!m_have_ref) begin
                        m_have_ref = 1; m_ref_g = m_pg; m_ref_b = m_b; m_run = 0;
                    end else if (m_pg != m_ref_g) begin
                        m_good = ($countones(m_pg ^ m_ref_g) == 1) &&
                                 (m_b == ((m_ref_b + 1) % (1 << N)));
                        if (m_good) begin
                            if (m_locked) begin
                                if (m_ref_b == (1 << N) - 1 && m_b == 0) begin
                                    e_wp = 1;
                                    e_wc = (e_wc + 1) % (1 << WRAP_W);
                                end
                            end else begin
                                m_run++;
                                if (m_run == LOCK_LEN) m_locked = 1;
                            end
                        end else begin
                            e_se = 1;
                            e_st = 1;
                            if (m_locked && e_ec < (1 << ERR_W) - 1) e_ec++;
                            m_locked = 0;
                            m_run = 0;
                        end
                        m_ref_g = m_pg; m_ref_b = m_b;
                    end
                end
                m_pv = en;
                m_pg = int'(gray_in);
            end
            check("bin_out",    int'(bin_out),    e_bin);
            check("bin_valid",  int'(bin_valid),  e_bv);
            check("locked",     int'(locked),     int'(m_locked));
            check("step_err",   int'(step_err),   e_se);
            check("err_sticky", int'(err_sticky), e_st);
            check("err_cnt",    int'(err_cnt),    e_ec);
            check("wrap_pulse", int'(wrap_pulse), e_wp);
            check("wrap_cnt",   int'(wrap_cnt),   e_wc);
            if (wrap_pulse) n_wp_seen++;
            if (step_err)   n_serr_seen++;
        end
    end

    task automatic drive(input logic e, input logic [N-1:0] g, input logic c);
        @(posedge clk);
        #2;
        en = e; gray_in = g; clr = c;
    endtask

    task automatic feed(input int b);
        drive(1'b1, bin2gray(b), 1'b0);
    endtask

    // Two bubbles let the last sample pass through both stages.
    task automatic settle();
        drive(1'b0, gray_in, 1'b0);
        drive(1'b0, gray_in, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bin_out"},    int'(bin_out),    0);
        check({tag, "_bin_valid"},  int'(bin_valid),  0);
        check({tag, "_locked"},     int'(locked),     0);
        check({tag, "_step_err"},   int'(step_err),   0);
        check({tag, "_err_sticky"}, int'(err_sticky), 0);
        check({tag, "_err_cnt"},    int'(err_cnt),    0);
        check({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
        check({tag, "_wrap_cnt"},   int'(wrap_cnt),   0);
    endtask

    int cur;
    int se0;

    initial begin : stimulus
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        $display("reset released");
        rst = 1'b1;

        // Acquisition: 0,1,3,2,6
        feed(0); feed(1); feed(2);
        feed(3);
        check("lock_early", int'(locked), 0);
        feed(4);
        check("lock_on_time", int'(locked), 1);
        settle();
        check("acq_bin_out", int'(bin_out), 4);
        check("acq_no_err", n_serr_seen, 0);
        $display("acquire: locked=%0d bin_out=%0d", locked, bin_out);

        // Two full laps
        for (int b = 5; b <= 16; b++) feed(b);
        settle();
        check("lap1_wrap_cnt", int'(wrap_cnt), 1);
        check("lap1_wrap_pulses", n_wp_seen, 1);
        $display("lap1: wrap_cnt=%0d", wrap_cnt);
        for (int b = 1; b <= 16; b++) feed(b);
        settle();
        check("lap2_wrap_cnt", int'(wrap_cnt), 2);
        check("lap2_wrap_pulses", n_wp_seen, 2);
        $display("lap2: wrap_cnt=%0d", wrap_cnt);

        // Two-bit jump from gray 3 to gray 5
        feed(1); feed(2);
        settle();
        drive(1'b1, 4'd5, 1'b0);
        settle();
        check("jump_serr", n_serr_seen, 1);
        check("jump_err_cnt", int'(err_cnt), 1);
        check("jump_sticky", int'(err_sticky), 1);
        check("jump_locked", int'(locked), 0);
        check("jump_bin_out", int'(bin_out), 6);
        feed(7); feed(8);
        settle();
        check("relock", int'(locked), 1);
        $display("jump: err_cnt=%0d relocked=%0d", err_cnt, locked);

        // Run to gray 2, clear, then step backward to gray 3
        for (int b = 9; b <= 19; b++) feed(b);
        settle();
        drive(1'b0, gray_in, 1'b1);
        settle();
        check("clr_err_cnt", int'(err_cnt), 0);
        check("clr_wrap_cnt", int'(wrap_cnt), 0);
        check("clr_sticky", int'(err_sticky), 0);
        check("clr_keeps_lock", int'(locked), 1);
        drive(1'b1, 4'd3, 1'b0);
        settle();
        check("back_err_cnt", int'(err_cnt), 1);
        check("back_serr", n_serr_seen, 2);
        check("back_locked", int'(locked), 0);
        check("back_bin_out", int'(bin_out), 2);
        $display("backward: err_cnt=%0d", err_cnt);

        // Repeats while locked, with and without en
        feed(3); feed(4);
        settle();
        drive(1'b1, 4'd6, 1'b0);
        drive(1'b1, 4'd6, 1'b0);
        drive(1'b0, 4'd7, 1'b0);
        settle();
        check("hold_locked", int'(locked), 1);
        check("hold_serr", n_serr_seen, 2);
        check("hold_err_cnt", int'(err_cnt), 1);
        check("hold_bin_out", int'(bin_out), 4);
        $display("hold: locked=%0d bin_out=%0d", locked, bin_out);

        // 256 locked errors saturate the counter
        cur = 4;
        se0 = n_serr_seen;
        repeat (256) begin
            feed(cur + 2); feed(cur + 3); feed(cur + 4);
            cur = (cur + 4) % 16;
        end
        settle();
        check("sat_err_cnt", int'(err_cnt), 255);
        check("sat_sticky", int'(err_sticky), 1);
        check("sat_locked", int'(locked), 1);
        check("sat_wrap_cnt", int'(wrap_cnt), 0);
        check("sat_serr", n_serr_seen - se0, 256);
        $display("saturate: err_cnt=%0d", err_cnt);

        // clr on the same edge as an error
        feed(cur + 2);
        drive(1'b1, bin2gray(cur + 3), 1'b1);
        feed(cur + 4);
        settle();
        check("clr_err_err_cnt", int'(err_cnt), 1);
        check("clr_err_sticky", int'(err_sticky), 1);
        check("clr_err_locked", int'(locked), 1);
        $display("clr+error: err_cnt=%0d sticky=%0d", err_cnt, err_sticky);
        cur = (cur + 4) % 16;

        // Asynchronous reset mid-run
        feed(cur + 1); feed(cur + 2);
        #3 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        $display("async reset: outputs cleared");
        en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        se0 = n_serr_seen;
        feed(5); feed(6); feed(7);
        settle();
        check("reacq_locked", int'(locked), 1);
        check("reacq_bin_out", int'(bin_out), 7);
        check("reacq_no_err", n_serr_seen - se0, 0);
        $display("reacquire: locked=%0d bin_out=%0d", locked, bin_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_seq_checker.md
# gray_seq_checker

Downstream consumer of the N-bit Gray counter. It samples the counter's Gray output and decodes it to binary. It checks every transition: exactly one bit may change, and the count must advance by +1 modulo 2^N. It reports lock status, wrap-arounds and step errors to the status/monitor logic.

## Interface
Parameters:
- N, 4, Gray/binary width; matches the upstream counter width
- LOCK_LEN, 2, consecutive valid steps required to declare lock (1..15)
- WRAP_W, 8, width of wrap counter (modulo 2^WRAP_W)
- ERR_W, 8, width of error counter (saturating)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset; clears all state and outputs
- en  in  1  sample qualifier; gray_in is taken only when en=1
- gray_in  in  N  Gray code from the upstream counter
- clr  in  1  synchronous clear of wrap_cnt, err_cnt, err_sticky (state/lock unaffected)
- bin_out  out  N  registered binary decode of last sample
- bin_valid  out  1  one-cycle pulse: bin_out updated
- locked  out  1  level: tracker in LOCKED state
- step_err  out  1  one-cycle pulse: illegal transition detected
- err_sticky  out  1  set by any step_err, cleared only by clr or rst
- err_cnt  out  ERR_W  errors while LOCKED, saturates at all-ones
- wrap_pulse  out  1  one-cycle pulse: legal LOCKED step 2^N-1 -> 0
- wrap_cnt  out  WRAP_W  wrap count, wraps modulo 2^WRAP_W

## Operation
- Stage 1: when en=1, register gray_in into s_gray and set s_v. When en=0, s_v=0.
- Stage 2 (s_v=1): decode b = gray-to-binary(s_gray) with an XOR prefix from the MSB. Compare against reference ref_g/ref_b. Register bin_out=b and pulse bin_valid.
- Hold: s_gray == ref_g. No step, no error, no state change. Sample count is unaffected. This covers an upstream counter held in reset.
- Valid step: popcount(s_gray ^ ref_g) == 1 and b == ref_b + 1 (mod 2^N).
- Illegal step: any other change, including a backward step or a multi-bit jump.
- On every non-hold sample, ref is updated to the new sample.
- FSM states: IDLE (no reference), ACQ (reference held, run counter k), LOCKED.
  - IDLE: the first sample loads ref, k=0, and moves to ACQ. It never produces an error.
  - ACQ, valid step: k++. If k reaches LOCK_LEN, move to LOCKED.
  - ACQ, illegal step: step_err pulse, err_sticky=1, k=0, stay in ACQ. err_cnt is not incremented.
  - LOCKED, valid step: stay. If ref_b == 2^N-1 and b == 0, pulse wrap_pulse and increment wrap_cnt.
  - LOCKED, illegal step: step_err, err_sticky=1, err_cnt++ (saturating), move to ACQ with k=0, locked drops.
- clr coincident with an event: the clear applies first, then the event. The result is err_cnt=1 / wrap_cnt=1 / err_sticky=1 as applicable.
- Wrap-around in ACQ is a valid step but is not counted.

## Timing
- Reset (rst=0, asynchronous) forces:
  - all outputs to 0: bin_out=0, bin_valid=0, locked=0, step_err=0, err_sticky=0, err_cnt=0, wrap_pulse=0, wrap_cnt=0;
  - state to IDLE and s_v to 0.
- Reset release is synchronous to clk. Reset mid-operation discards the reference; the next sample re-enters IDLE->ACQ.
- Latency: gray_in sampled at edge T (en=1) produces bin_out, bin_valid, step_err, wrap_pulse, locked and the counter updates at edge T+1. Outputs are visible after T+1.
- Pulses (bin_valid, step_err, wrap_pulse) last exactly one cycle per sample.
- Full throughput: one sample per clock with en held high.
- en=0 cycles insert bubbles. State and outputs hold, except that pulses deassert.
- err_cnt at all-ones stays all-ones on further errors. err_sticky remains 1.

## Test plan
- Reset, then en=1 with the upstream counter free-running 0,1,3,2,6 (N=4, LOCK_LEN=2): locked=1 one cycle after the sample of 3 is taken; bin_out follows 0,1,2,3,4; no step_err.
- Locked run over 16 steps from 15 (gray 8) to 0 (gray 0): exactly one wrap_pulse, wrap_cnt=1. A second full lap gives wrap_cnt=2.
- Locked at gray 3, then inject gray 5 (two bits change): step_err pulse, err_cnt=1, err_sticky=1, locked=0. Two further valid steps relock.
- Backward single-bit step while locked (gray 2 then 3): step_err, err_cnt=1.
- Repeated gray value while locked: no error, locked stays 1. The same repeat with en=0 changes nothing.
- 256 forced errors with ERR_W=8: err_cnt saturates at 255. Then clr coincident with an error gives err_cnt=1, err_sticky=1. Asserting rst mid-run clears all outputs to 0 immediately, without waiting for a clock edge.
